td4_run_ctrl: RTL and testbench

//  Run/step/halt sequencer for the 4-bit TD4-style core. Turns three raw board buttons into

---
 rtl/td4_ctrl_pkg.sv | 17 +
 rtl/btn_conditioner.sv | 53 +++++
 rtl/td4_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_td4_run_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/td4_ctrl_pkg.sv
// Shared encodings for the TD4 run/step/halt sequencer.
// The state codes are also shown by the top level, so they are fixed here.
package td4_ctrl_pkg;

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_RST  = 2'b11;

    typedef enum logic [1:0] {
        S_HALT = ST_HALT,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_RST  = ST_RST
    } ctrl_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button conditioner: 2-FF synchroniser, debounce counter and
// rising-edge detector. press_o is a single-clk pulse issued once the
// synchronised level has been stable and high for DB_CYC+1 cycles.
module btn_conditioner #(
    parameter logic [15:0] DB_CYC = 16'd49_999
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn_i,
    output logic press_o
);

    logic        sync1_q, sync2_q;
    logic        stable_q, stable_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_q, press_d;

    // Debounce: count while the synchronised level differs from the accepted
    // level; accept it after DB_CYC+1 consecutive differing cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_CYC) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Synchroniser, debounce state and registered press pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/td4_run_ctrl.sv
// Run/step/halt sequencer for the 4-bit TD4-style core. Produces the core's
// clock-enable pulses (divided free-run or single-step), drives the core
// reset and halts on a breakpoint address match. All outputs are registered.
module td4_run_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter logic [23:0] DIV_MAX = 24'd5_999_999,
    parameter logic [15:0] DB_CYC  = 16'd49_999,
    parameter logic [3:0]  RST_CYC = 4'd8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_rst,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] cpu_addr,
    output logic       cpu_ce,
    output logic       cpu_n_reset,
    output logic [1:0] state,
    output logic [7:0] retired
);

    logic run_p, step_p, rst_p;

    btn_conditioner #(.DB_CYC(DB_CYC)) u_btn_run (
        .clk(clk), .n_reset(n_reset), .btn_i(btn_run), .press_o(run_p)
    );
    btn_conditioner #(.DB_CYC(DB_CYC)) u_btn_step (
        .clk(clk), .n_reset(n_reset), .btn_i(btn_step), .press_o(step_p)
    );
    btn_conditioner #(.DB_CYC(DB_CYC)) u_btn_rst (
        .clk(clk), .n_reset(n_reset), .btn_i(btn_rst), .press_o(rst_p)
    );

    logic        bp_en_s1_q, bp_en_s2_q;
    logic [3:0]  bp_addr_s1_q, bp_addr_s2_q;

    ctrl_state_e state_q, state_d;
    logic [23:0] div_q, div_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [7:0]  retired_q, retired_d;
    logic        bp_skip_q, bp_skip_d;
    logic        cpu_ce_q, cpu_ce_d;
    logic        cpu_n_reset_q, cpu_n_reset_d;

    logic tick, bp_hit;

    assign tick   = (div_q == DIV_MAX);
    assign bp_hit = bp_en_s2_q && (cpu_addr == bp_addr_s2_q);

    // Next-state and registered-output logic; rst press beats run beats step.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        rst_cnt_d     = rst_cnt_q;
        retired_d     = retired_q;
        bp_skip_d     = bp_skip_q;
        cpu_ce_d      = 1'b0;
        cpu_n_reset_d = 1'b1;
        if (rst_p) begin
            state_d       = S_RST;
            rst_cnt_d     = '0;
            retired_d     = '0;
            div_d         = '0;
            cpu_n_reset_d = 1'b0;
        end else begin
            case (state_q)
                S_RST: begin
                    retired_d     = '0;
                    div_d         = '0;
                    cpu_n_reset_d = 1'b0;
                    if (rst_cnt_q == RST_CYC - 4'd1) begin
                        state_d       = S_HALT;
                        rst_cnt_d     = '0;
                        cpu_n_reset_d = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 4'd1;
                    end
                end
                S_HALT: begin
                    if (run_p) begin
                        state_d   = S_RUN;
                        div_d     = '0;
                        bp_skip_d = 1'b1;
                    end else if (step_p) begin
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    cpu_ce_d  = 1'b1;
                    retired_d = retired_q + 8'd1;
                    state_d   = S_HALT;
                end
                S_RUN: begin
                    div_d = tick ? '0 : div_q + 24'd1;
                    if (run_p) begin
                        // A tick landing in the same cycle is dropped.
                        state_d = S_HALT;
                    end else if (tick) begin
                        if (bp_hit && !bp_skip_q) begin
                            // Stop before executing the breakpointed instruction.
                            state_d = S_HALT;
                        end else begin
                            cpu_ce_d  = 1'b1;
                            retired_d = retired_q + 8'd1;
                            bp_skip_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_RST;
            endcase
        end
    end

    // State, counters, breakpoint synchroniser and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bp_en_s1_q    <= 1'b0;
            bp_en_s2_q    <= 1'b0;
            bp_addr_s1_q  <= '0;
            bp_addr_s2_q  <= '0;
            state_q       <= S_RST;
            div_q         <= '0;
            rst_cnt_q     <= '0;
            retired_q     <= '0;
            bp_skip_q     <= 1'b0;
            cpu_ce_q      <= 1'b0;
            cpu_n_reset_q <= 1'b0;
        end else begin
            bp_en_s1_q    <= bp_en;
            bp_en_s2_q    <= bp_en_s1_q;
            bp_addr_s1_q  <= bp_addr;
            bp_addr_s2_q  <= bp_addr_s1_q;
            state_q       <= state_d;
            div_q         <= div_d;
            rst_cnt_q     <= rst_cnt_d;
            retired_q     <= retired_d;
            bp_skip_q     <= bp_skip_d;
            cpu_ce_q      <= cpu_ce_d;
            cpu_n_reset_q <= cpu_n_reset_d;
        end
    end

    assign cpu_ce      = cpu_ce_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl with short timing constants: a cycle-by-cycle vector
// table for reset/step/glitch, then hand sequences for run, wrap, breakpoint,
// reset priority and asynchronous reset. The bench plays the core: cpu_addr
// advances on every observed cpu_ce and clears while cpu_n_reset is low.
module tb_td4_run_ctrl;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       btn_run, btn_step, btn_rst, bp_en;
    logic [3:0] bp_addr, cpu_addr;
    logic       cpu_ce, cpu_n_reset;
    logic [1:0] state;
    logic [7:0] retired;

    td4_run_ctrl #(.DIV_MAX(24'd3), .DB_CYC(16'd3), .RST_CYC(4'd4)) dut (
        .clk(clk), .n_reset(n_reset), .btn_run(btn_run), .btn_step(btn_step),
        .btn_rst(btn_rst), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_addr(cpu_addr),
        .cpu_ce(cpu_ce), .cpu_n_reset(cpu_n_reset), .state(state), .retired(retired)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic       step;
        logic [1:0] st;
        logic       ce;
        logic       nrst;
        logic [7:0] ret;
    } vec_t;

    vec_t vecs[1:28];

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc_no = 0;
    int         ce_cnt = 0;
    int         bad_ce = 0;
    int         last_ce_cyc = -1;
    int         period_bad = 0;
    bit         period_chk = 0;
    bit         first_pending = 0;
    logic [3:0] first_ce_addr = 4'h0;
    logic [7:0] model_ret = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge and advance the core model.
    task automatic cyc();
        @(negedge clk);
        cyc_no++;
        if (cpu_ce && !cpu_n_reset) bad_ce++;
        if (!cpu_n_reset) begin
            cpu_addr  = 4'h0;
            model_ret = 8'h0;
        end else if (cpu_ce) begin
            if (first_pending) begin
                first_ce_addr = cpu_addr;
                first_pending = 0;
            end
            if (period_chk && last_ce_cyc >= 0 && (cyc_no - last_ce_cyc) != 4) period_bad++;
            last_ce_cyc = cyc_no;
            cpu_addr  = cpu_addr + 4'h1;
            model_ret = model_ret + 8'h1;
            ce_cnt++;
        end
    endtask

    task automatic wait_state(input logic [1:0] exp, input int bound, input string name);
        int n = 0;
        while (state !== exp && n < bound) begin
            cyc();
            n++;
        end
        check(name, {30'd0, state}, {30'd0, exp});
    endtask

    task automatic set_vec(input int n, input logic step, input logic [1:0] st,
                           input logic ce, input logic nrst, input logic [7:0] ret);
        vecs[n].step = step;
        vecs[n].st   = st;
        vecs[n].ce   = ce;
        vecs[n].nrst = nrst;
        vecs[n].ret  = ret;
    endtask

    task automatic press_run_until_run(input string name);
        btn_run = 1'b1;
        wait_state(2'b01, 20, name);
        btn_run = 1'b0;
    endtask

    initial begin
        int a0, c0, exp_n, n;
        string nm;

        // Vectors: index n = inputs applied before posedge n after reset release.
        for (int i = 1; i <= 3; i++)   set_vec(i, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0);
        set_vec(4, 1'b0, 2'b00, 1'b0, 1'b1, 8'd0);
        for (int i = 5; i <= 10; i++)  set_vec(i, 1'b1, 2'b00, 1'b0, 1'b1, 8'd0);
        set_vec(11, 1'b1, 2'b10, 1'b0, 1'b1, 8'd0);
        set_vec(12, 1'b1, 2'b00, 1'b1, 1'b1, 8'd1);
        for (int i = 13; i <= 18; i++) set_vec(i, 1'b0, 2'b00, 1'b0, 1'b1, 8'd1);
        for (int i = 19; i <= 20; i++) set_vec(i, 1'b1, 2'b00, 1'b0, 1'b1, 8'd1);
        for (int i = 21; i <= 28; i++) set_vec(i, 1'b0, 2'b00, 1'b0, 1'b1, 8'd1);

        n_reset = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_rst = 1'b0;
        bp_en = 1'b0; bp_addr = 4'h0; cpu_addr = 4'h0;

        // reset values
        cyc();
        cyc();
        check("reset_outputs", {20'd0, state, cpu_ce, cpu_n_reset, retired}, 32'h0000_0C00);

        // 1/2: reset release, single step, short glitch
        n_reset = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            btn_step = vecs[i].step;
            cyc();
            nm = $sformatf("vec[%0d] st/ce/nrst/ret", i);
            check(nm, {20'd0, state, cpu_ce, cpu_n_reset, retired},
                  {20'd0, vecs[i].st, vecs[i].ce, vecs[i].nrst, vecs[i].ret});
        end

        // 3: free run, period 4, retired wrap at 256
        ce_cnt = 0;
        last_ce_cyc = -1;
        period_chk = 1;
        btn_run = 1'b1;
        wait_state(2'b01, 20, "t3_enter_run");
        n = 0;
        while (!cpu_ce && n < 20) begin
            cyc();
            n++;
        end
        check("t3_first_ce_latency", n, 4);
        btn_run = 1'b0;
        n = 0;
        while (ce_cnt < 255 && n < 1200) begin
            cyc();
            n++;
        end
        check("t3_pulses_255", ce_cnt, 255);
        check("t3_retired_wrap", {24'd0, retired}, 32'd0);
        check("t3_period_errors", period_bad, 0);
        period_chk = 0;
        btn_run = 1'b1;
        wait_state(2'b00, 20, "t3_second_press_halt");
        btn_run = 1'b0;
        c0 = ce_cnt;
        repeat (20) cyc();
        check("t3_no_ce_after_halt", ce_cnt, c0);
        check("t3_retired_model", {24'd0, retired}, {24'd0, model_ret});

        // 4: breakpoint at 5, then resume executes 5 and halts on next pass
        bp_en = 1'b1;
        bp_addr = 4'h5;
        repeat (4) cyc();
        a0 = int'(cpu_addr);
        c0 = ce_cnt;
        exp_n = (5 - a0) & 15;
        if (exp_n == 0) exp_n = 16;
        press_run_until_run("t4_enter_run");
        wait_state(2'b00, 200, "t4_bp_halt");
        check("t4_halt_addr", {28'd0, cpu_addr}, 32'd5);
        check("t4_pulses_before_bp", ce_cnt - c0, exp_n);
        repeat (10) cyc();
        c0 = ce_cnt;
        first_pending = 1;
        press_run_until_run("t4_resume_run");
        wait_state(2'b00, 200, "t4_bp_halt_again");
        check("t4_first_exec_addr", {28'd0, first_ce_addr}, 32'd5);
        check("t4_pulses_full_pass", ce_cnt - c0, 16);
        check("t4_halt_addr_again", {28'd0, cpu_addr}, 32'd5);
        check("t4_retired_model", {24'd0, retired}, {24'd0, model_ret});
        repeat (10) cyc();

        // 5: rst and run pressed together while running -> rst wins
        bp_en = 1'b0;
        press_run_until_run("t5_enter_run");
        repeat (10) cyc();
        btn_run = 1'b1;
        btn_rst = 1'b1;
        n = 0;
        while (state === 2'b01 && n < 20) begin
            cyc();
            n++;
        end
        check("t5_rst_wins_state", {30'd0, state}, 32'd3);
        n = 0;
        while (!cpu_n_reset && n < 20) begin
            n++;
            cyc();
        end
        check("t5_cpu_n_reset_low_cycles", n, 4);
        check("t5_state_halt", {30'd0, state}, 32'd0);
        check("t5_retired_cleared", {24'd0, retired}, 32'd0);
        btn_run = 1'b0;
        btn_rst = 1'b0;
        repeat (10) cyc();

        // 6: asynchronous reset while cpu_ce is high
        press_run_until_run("t6_enter_run");
        n = 0;
        while (!cpu_ce && n < 40) begin
            cyc();
            n++;
        end
        check("t6_ce_seen", {31'd0, cpu_ce}, 32'd1);
        n_reset = 1'b0;
        #1;
        check("t6_async_reset_outputs", {20'd0, state, cpu_ce, cpu_n_reset, retired}, 32'h0000_0C00);
        cyc();
        n_reset = 1'b1;
        wait_state(2'b00, 10, "t6_back_to_halt");
        check("t6_cpu_n_reset_high", {31'd0, cpu_n_reset}, 32'd1);
        check("ce_during_core_reset", bad_ce, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
